cnt_cam_ctrl: RTL and testbench

Sequencer for the 64/68-entry activation-counter CAM (`cnt_cam_64`).
- Handles per-activation counting: accepts ACT events tagged with a counter entry and performs a saturating read-increment-write on that entry.
- Handles RFM service: on request, runs the CAM's 4-phase max search, locates the hottest entry by value search, clears it and reports it.
- Sits between the DRAM command front-end and the CAM; it is the only master of the CAM ports.

---
 rtl/cnt_cam_pkg.sv | 29 ++
 rtl/cnt_cam_ctrl_if.sv | 40 ++++
 rtl/cnt_cam_ctrl_sat_inc.sv | 28 ++
 rtl/cnt_cam_ctrl.sv | 172 +++++++++++++++++
 tb/tb_cnt_cam_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnt_cam_pkg.sv
// rtl/cnt_cam_pkg.sv - shared defaults, FSM state type and saturating increment for the CAM sequencer
//
// Purpose : common definitions imported by the counter-CAM controller files.
// Contents: DEF_WORD_SIZE / DEF_ENTRY_WIDTH / DEF_ROW_NUM defaults,
//           cam_state_t FSM encoding, sat_inc_f saturating increment.
package cnt_cam_pkg;

   localparam int DEF_WORD_SIZE   = 16;
   localparam int DEF_ENTRY_WIDTH = 7;
   localparam int DEF_ROW_NUM     = 68;

   typedef enum logic [3:0] {
      ST_INIT,
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_MAX,
      ST_MAXL,
      ST_SRCH,
      ST_CLR,
      ST_ACK
   } cam_state_t;

   // All-ones is sticky so a hot row never wraps back to a cold count.
   function automatic logic [DEF_WORD_SIZE-1:0] sat_inc_f(input logic [DEF_WORD_SIZE-1:0] v);
      return (&v) ? v : v + DEF_WORD_SIZE'(1);
   endfunction

endpackage

// File: rtl/cnt_cam_ctrl_if.sv
// rtl/cnt_cam_ctrl_if.sv - controller-to-CAM port bundle
//
// Purpose : groups every CAM control/data signal the sequencer drives or samples.
// Modports: master - the controller (drives strobes, address, write/search data)
//           slave  - the CAM (returns read data, search result, max result)
// Signals : cam_data_in, cam_addr_in, cam_read_en, cam_write_en, cam_search_en,
//           cam_reset, cam_max_en (master->slave); cam_data_out, cam_addr_out,
//           cam_match, cam_max (slave->master)
interface cnt_cam_ctrl_if
   import cnt_cam_pkg::*;
#(
   parameter int WORD_SIZE   = DEF_WORD_SIZE,
   parameter int ENTRY_WIDTH = DEF_ENTRY_WIDTH
);

   logic [WORD_SIZE-1:0]   cam_data_in;
   logic [ENTRY_WIDTH-1:0] cam_addr_in;
   logic                   cam_read_en;
   logic                   cam_write_en;
   logic                   cam_search_en;
   logic                   cam_reset;
   logic                   cam_max_en;
   logic [WORD_SIZE-1:0]   cam_data_out;
   logic [ENTRY_WIDTH-1:0] cam_addr_out;
   logic                   cam_match;
   logic [WORD_SIZE-1:0]   cam_max;

   modport master (
      output cam_data_in, cam_addr_in, cam_read_en, cam_write_en,
             cam_search_en, cam_reset, cam_max_en,
      input  cam_data_out, cam_addr_out, cam_match, cam_max
   );

   modport slave (
      input  cam_data_in, cam_addr_in, cam_read_en, cam_write_en,
             cam_search_en, cam_reset, cam_max_en,
      output cam_data_out, cam_addr_out, cam_match, cam_max
   );

endinterface

// File: rtl/cnt_cam_ctrl_sat_inc.sv
// rtl/cnt_cam_ctrl_sat_inc.sv - saturating incrementer with threshold compare
//
// Purpose : next count for a read-increment-write, plus "reached threshold" flag.
// Ports   : value_in  in  W  current count
//           value_out out W  count+1, held at all-ones
//           at_th     out 1  value_out >= TH
module sat_inc
   import cnt_cam_pkg::*;
#(
   parameter int           W  = DEF_WORD_SIZE,
   parameter logic [W-1:0] TH = W'(64)
) (
   input  logic [W-1:0] value_in,
   output logic [W-1:0] value_out,
   output logic         at_th
);

   generate
      if (W == DEF_WORD_SIZE) begin : g_pkg
         assign value_out = sat_inc_f(value_in);
      end else begin : g_gen
         assign value_out = (&value_in) ? value_in : value_in + W'(1);
      end
   endgenerate

   assign at_th = (value_out >= TH);

endmodule

// File: rtl/cnt_cam_ctrl.sv
// rtl/cnt_cam_ctrl.sv - activation-counter CAM sequencer (ACT counting + RFM service)
//
// Purpose : sole master of the counter CAM. Counts ACTs with a saturating
//           read-increment-write and services RFM requests by max search,
//           value search and clear of the hottest entry.
// Ports   : clk, rst (async, active-high)
//           act_valid/act_entry/act_ready   - ACT event handshake
//           rfm_req                         - level request for one RFM service
//           rfm_ack/rfm_hit/rfm_entry/rfm_count - RFM result, valid with rfm_ack
//           alert                           - sticky threshold flag, cleared by RFM
//           cam                             - CAM bundle (master side)
module cnt_cam_ctrl
   import cnt_cam_pkg::*;
#(
   parameter int                   WORD_SIZE   = DEF_WORD_SIZE,
   parameter int                   ENTRY_WIDTH = DEF_ENTRY_WIDTH,
   parameter int                   ROW_NUM     = DEF_ROW_NUM,
   parameter logic [WORD_SIZE-1:0] RFM_TH      = WORD_SIZE'(64)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   act_valid,
   input  logic [ENTRY_WIDTH-1:0] act_entry,
   output logic                   act_ready,
   input  logic                   rfm_req,
   output logic                   rfm_ack,
   output logic                   rfm_hit,
   output logic [ENTRY_WIDTH-1:0] rfm_entry,
   output logic [WORD_SIZE-1:0]   rfm_count,
   output logic                   alert,
   cnt_cam_ctrl_if.master         cam
);

   localparam logic [ENTRY_WIDTH-1:0] ROW_LIM = ENTRY_WIDTH'(ROW_NUM);

   cam_state_t             state, state_nx;
   logic [ENTRY_WIDTH-1:0] entry_q;
   logic [WORD_SIZE-1:0]   cnt_q;
   logic [1:0]             phase_q;
   logic [WORD_SIZE-1:0]   max_q;
   logic [ENTRY_WIDTH-1:0] found_q;
   logic                   match_q;
   logic                   alert_q;
   logic [WORD_SIZE-1:0]   inc_val;
   logic                   inc_at_th;

   sat_inc #(
      .W  (WORD_SIZE),
      .TH (RFM_TH)
   ) u_sat_inc (
      .value_in  (cnt_q),
      .value_out (inc_val),
      .at_th     (inc_at_th)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_INIT;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_INIT: state_nx = ST_IDLE;
         ST_IDLE: begin
            if (rfm_req) begin
               state_nx = ST_MAX;
            end else if (act_valid && (act_entry < ROW_LIM)) begin
               state_nx = ST_RD;
            end
            // Out-of-range ACTs are consumed here without touching the CAM.
         end
         ST_RD:   state_nx = ST_WR;
         ST_WR:   state_nx = ST_IDLE;
         ST_MAX:  if (phase_q == 2'd3) state_nx = ST_MAXL;
         // Decide on the live CAM result; max_q captures the same value this edge.
         ST_MAXL: state_nx = (cam.cam_max == '0) ? ST_ACK : ST_SRCH;
         ST_SRCH: state_nx = ST_CLR;
         ST_CLR:  state_nx = ST_ACK;
         ST_ACK:  state_nx = ST_IDLE;
         default: state_nx = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q <= '0;
         cnt_q   <= '0;
         phase_q <= '0;
         max_q   <= '0;
         found_q <= '0;
         match_q <= 1'b0;
         alert_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               phase_q <= '0;
               // Cleared so an empty RFM (skipping SRCH) reports no hit.
               match_q <= 1'b0;
               if (!rfm_req && act_valid) entry_q <= act_entry;
            end
            ST_RD:   cnt_q <= cam.cam_data_out;
            ST_WR:   if (inc_at_th) alert_q <= 1'b1;
            ST_MAX:  phase_q <= phase_q + 2'd1;
            ST_MAXL: max_q <= cam.cam_max;
            ST_SRCH: begin
               found_q <= cam.cam_addr_out;
               match_q <= cam.cam_match;
            end
            ST_ACK:  alert_q <= 1'b0;
            default: ;
         endcase
      end
   end

   // Outputs are forced low while rst is held, even though state already reads INIT.
   always_comb begin
      act_ready         = 1'b0;
      rfm_ack           = 1'b0;
      rfm_hit           = 1'b0;
      rfm_entry         = '0;
      rfm_count         = '0;
      alert             = 1'b0;
      cam.cam_data_in   = '0;
      cam.cam_addr_in   = '0;
      cam.cam_read_en   = 1'b0;
      cam.cam_write_en  = 1'b0;
      cam.cam_search_en = 1'b0;
      cam.cam_reset     = 1'b0;
      cam.cam_max_en    = 1'b0;
      if (!rst) begin
         alert = alert_q;
         case (state)
            ST_INIT: cam.cam_reset = 1'b1;
            ST_IDLE: act_ready = 1'b1;
            ST_RD: begin
               cam.cam_read_en = 1'b1;
               cam.cam_addr_in = entry_q;
            end
            ST_WR: begin
               cam.cam_write_en = 1'b1;
               cam.cam_addr_in  = entry_q;
               cam.cam_data_in  = inc_val;
            end
            ST_MAX:  cam.cam_max_en = 1'b1;
            ST_SRCH: begin
               cam.cam_search_en = 1'b1;
               cam.cam_data_in   = max_q;
            end
            ST_CLR: begin
               if (match_q) begin
                  cam.cam_write_en = 1'b1;
                  cam.cam_addr_in  = found_q;
               end
            end
            ST_ACK: begin
               rfm_ack = 1'b1;
               rfm_hit = match_q;
               if (match_q) begin
                  rfm_entry = found_q;
                  rfm_count = max_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cnt_cam_ctrl.sv
// tb/tb_cnt_cam_ctrl.sv - self-checking bench for cnt_cam_ctrl with a behavioural CAM
module tb_cnt_cam_ctrl;

   localparam int RN = 68;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        act_valid = 1'b0;
   logic [6:0]  act_entry = '0;
   logic        act_ready;
   logic        rfm_req = 1'b0;
   logic        rfm_ack;
   logic        rfm_hit;
   logic [6:0]  rfm_entry;
   logic [15:0] rfm_count;
   logic        alert;

   int checks = 0;
   int failures = 0;

   cnt_cam_ctrl_if #(.WORD_SIZE(16), .ENTRY_WIDTH(7)) cam_bus ();

   cnt_cam_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .act_valid (act_valid),
      .act_entry (act_entry),
      .act_ready (act_ready),
      .rfm_req   (rfm_req),
      .rfm_ack   (rfm_ack),
      .rfm_hit   (rfm_hit),
      .rfm_entry (rfm_entry),
      .rfm_count (rfm_count),
      .alert     (alert),
      .cam       (cam_bus)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural CAM ----------------
   logic [15:0] mem [0:RN-1];
   logic [15:0] max_r = '0;
   logic [1:0]  mode = '0;
   logic        pre_en = 1'b0;
   logic [6:0]  pre_addr = '0;
   logic [15:0] pre_val = '0;

   function automatic logic [15:0] mem_max();
      logic [15:0] m = '0;
      for (int i = 0; i < RN; i++) if (mem[i] > m) m = mem[i];
      return m;
   endfunction

   always @(posedge clk) begin
      if (cam_bus.cam_reset) begin
         for (int i = 0; i < RN; i++) mem[i] <= '0;
      end else if (cam_bus.cam_write_en && int'(cam_bus.cam_addr_in) < RN) begin
         mem[int'(cam_bus.cam_addr_in)] <= cam_bus.cam_data_in;
      end else if (pre_en) begin
         mem[int'(pre_addr)] <= pre_val;
      end
      if (cam_bus.cam_max_en) begin
         if (mode == 2'd3) begin
            max_r <= mem_max();
            mode  <= 2'd0;
         end else begin
            mode <= mode + 2'd1;
         end
      end else begin
         mode <= 2'd0;
      end
   end

   always_comb begin
      cam_bus.cam_data_out = '0;
      if (cam_bus.cam_read_en && int'(cam_bus.cam_addr_in) < RN)
         cam_bus.cam_data_out = mem[int'(cam_bus.cam_addr_in)];
   end

   always_comb begin
      cam_bus.cam_match    = 1'b0;
      cam_bus.cam_addr_out = '0;
      if (cam_bus.cam_search_en) begin
         for (int i = RN - 1; i >= 0; i--) begin
            if (mem[i] == cam_bus.cam_data_in) begin
               cam_bus.cam_match    = 1'b1;
               cam_bus.cam_addr_out = 7'(i);
            end
         end
      end
   end

   assign cam_bus.cam_max = max_r;

   // ---------------- reference model ----------------
   int unsigned exp_cnt [RN];
   bit          exp_alert = 1'b0;

   function automatic void model_clear();
      for (int i = 0; i < RN; i++) exp_cnt[i] = 0;
      exp_alert = 1'b0;
   endfunction

   function automatic void model_act(input int e);
      if (e < RN) begin
         if (exp_cnt[e] < 65535) exp_cnt[e] = exp_cnt[e] + 1;
         if (exp_cnt[e] >= 64) exp_alert = 1'b1;
      end
   endfunction

   // Hottest entry, lowest index on ties; zero max means nothing to clear.
   function automatic void model_rfm(output bit hit, output int ent, output int cnt);
      int best = 0;
      hit = 1'b0; ent = 0; cnt = 0;
      for (int i = 0; i < RN; i++) if (exp_cnt[i] > exp_cnt[best]) best = i;
      if (exp_cnt[best] != 0) begin
         hit = 1'b1; ent = best; cnt = int'(exp_cnt[best]);
         exp_cnt[best] = 0;
      end
      exp_alert = 1'b0;
   endfunction

   // ---------------- helpers ----------------
   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (act_ready !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (act_ready !== 1'b1) begin
         failures++;
         $display("FAIL wait_idle: act_ready=%b required 1", act_ready);
      end
   endtask

   task automatic preload(input int a, input logic [15:0] v);
      @(negedge clk);
      pre_en = 1'b1; pre_addr = 7'(a); pre_val = v;
      @(negedge clk);
      pre_en = 1'b0;
      exp_cnt[a] = v;
   endtask

   task automatic check_all_zero(input string tag);
      logic [63:0] v;
      v = {act_ready, rfm_ack, rfm_hit, rfm_entry, rfm_count, alert,
           cam_bus.cam_data_in, cam_bus.cam_addr_in, cam_bus.cam_read_en,
           cam_bus.cam_write_en, cam_bus.cam_search_en, cam_bus.cam_reset,
           cam_bus.cam_max_en};
      checks++;
      if (v !== '0) begin
         failures++;
         $display("FAIL %s outputs during rst: got %h required 0", tag, v);
      end
   endtask

   task automatic reset_dut(input string tag);
      @(negedge clk);
      rst = 1'b1;
      act_valid = 1'b0;
      rfm_req = 1'b0;
      #1 check_all_zero(tag);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      #1;
      checks++;
      if (cam_bus.cam_reset !== 1'b1) begin
         failures++;
         $display("FAIL %s cam_reset after release: got %b required 1", tag, cam_bus.cam_reset);
      end
      @(negedge clk);
      checks++;
      if (cam_bus.cam_reset !== 1'b0 || act_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s post-init: cam_reset=%b act_ready=%b required 0/1", tag, cam_bus.cam_reset, act_ready);
      end
   endtask

   task automatic act_and_check(input int e);
      wait_idle();
      act_valid = 1'b1;
      act_entry = 7'(e);
      @(posedge clk);
      #1 act_valid = 1'b0;
      model_act(e);
      if (e >= RN) begin
         @(negedge clk);
         checks++;
         if (act_ready !== 1'b1 || cam_bus.cam_read_en !== 1'b0 || cam_bus.cam_write_en !== 1'b0) begin
            failures++;
            $display("FAIL act_oor e=%0d: ready=%b rd=%b wr=%b required 1/0/0", e, act_ready,
                     cam_bus.cam_read_en, cam_bus.cam_write_en);
         end
      end
      wait_idle();
      checks++;
      if (alert !== exp_alert) begin
         failures++;
         $display("FAIL act_alert e=%0d: got %b required %b", e, alert, exp_alert);
      end
      if (e < RN) begin
         checks++;
         if (mem[e] !== 16'(exp_cnt[e])) begin
            failures++;
            $display("FAIL act_count e=%0d: got %0d required %0d", e, mem[e], exp_cnt[e]);
         end
      end
   endtask

   // Runs one RFM; with_act also raises act_valid in the same IDLE cycle and leaves it high.
   task automatic do_rfm(input bit with_act, input int act_e);
      bit hit; int ent; int cnt; int lat; int ack_k = 0; int max_cycles = 0; int busy_bad = 0;
      wait_idle();
      rfm_req = 1'b1;
      if (with_act) begin
         act_valid = 1'b1;
         act_entry = 7'(act_e);
      end
      model_rfm(hit, ent, cnt);
      lat = hit ? 8 : 6;
      @(posedge clk);
      #1 rfm_req = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (cam_bus.cam_max_en === 1'b1) max_cycles++;
         if (act_ready !== 1'b0) busy_bad++;
         if (rfm_ack === 1'b1) begin
            ack_k = k;
            checks++;
            if (rfm_hit !== hit || rfm_entry !== 7'(ent) || rfm_count !== 16'(cnt)) begin
               failures++;
               $display("FAIL rfm_result: hit=%b entry=%0d count=%0d required %b/%0d/%0d",
                        rfm_hit, rfm_entry, rfm_count, hit, ent, cnt);
            end
            break;
         end
      end
      checks++;
      if (ack_k != lat) begin
         failures++;
         $display("FAIL rfm_latency: got %0d required %0d", ack_k, lat);
      end
      checks++;
      if (max_cycles != 4) begin
         failures++;
         $display("FAIL rfm_max_en_cycles: got %0d required 4", max_cycles);
      end
      checks++;
      if (busy_bad != 0) begin
         failures++;
         $display("FAIL rfm_act_ready_low: got %0d high cycles required 0", busy_bad);
      end
      if (!with_act) begin
         wait_idle();
         checks++;
         if (alert !== 1'b0 || mem[ent] !== 16'(exp_cnt[ent])) begin
            failures++;
            $display("FAIL rfm_after: alert=%b mem[%0d]=%0d required 0/%0d", alert, ent, mem[ent], exp_cnt[ent]);
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      preload(5, 16'hBEEF);
      reset_dut("init");
      checks++;
      if (mem[5] !== 16'h0000) begin
         failures++;
         $display("FAIL init_clear: mem[5]=%h required 0000", mem[5]);
      end
   endtask

   task automatic test_counting();
      wait_idle();
      act_valid = 1'b1;
      act_entry = 7'd5;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if (act_ready !== (i % 3 == 0)) begin
            failures++;
            $display("FAIL count_ready cycle %0d: got %b required %b", i, act_ready, (i % 3 == 0));
         end
      end
      act_valid = 1'b0;
      for (int i = 0; i < 3; i++) model_act(5);
      wait_idle();
      checks++;
      if (mem[5] !== 16'd3 || alert !== 1'b0) begin
         failures++;
         $display("FAIL count_value: mem[5]=%0d alert=%b required 3/0", mem[5], alert);
      end
   endtask

   task automatic test_saturation_alert();
      preload(20, 16'd62);
      act_and_check(20);
      act_and_check(20);
      do_rfm(1'b0, 0);
      preload(2, 16'hFFFF);
      act_and_check(2);
   endtask

   task automatic test_rfm_hit();
      reset_dut("pre_hit");
      preload(10, 16'd7);
      preload(3, 16'd2);
      do_rfm(1'b0, 0);
   endtask

   task automatic test_empty_priority();
      reset_dut("pre_empty");
      do_rfm(1'b1, 7);
      @(negedge clk);
      checks++;
      if (act_ready !== 1'b1) begin
         failures++;
         $display("FAIL prio_act_ready: got %b required 1", act_ready);
      end
      @(posedge clk);
      #1 act_valid = 1'b0;
      model_act(7);
      wait_idle();
      checks++;
      if (mem[7] !== 16'd1) begin
         failures++;
         $display("FAIL prio_act_count: mem[7]=%0d required 1", mem[7]);
      end
   endtask

   task automatic test_reset_mid_rfm();
      int acks = 0;
      preload(10, 16'd5);
      wait_idle();
      rfm_req = 1'b1;
      @(posedge clk);
      #1 rfm_req = 1'b0;
      for (int k = 1; k <= 6; k++) @(negedge clk);
      checks++;
      if (cam_bus.cam_search_en !== 1'b1) begin
         failures++;
         $display("FAIL midrfm_in_srch: search_en=%b required 1", cam_bus.cam_search_en);
      end
      rst = 1'b1;
      #1 check_all_zero("midrfm");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      #1;
      checks++;
      if (cam_bus.cam_reset !== 1'b1) begin
         failures++;
         $display("FAIL midrfm_cam_reset: got %b required 1", cam_bus.cam_reset);
      end
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (rfm_ack === 1'b1) acks++;
      end
      checks++;
      if (acks != 0 || mem[10] !== 16'd0) begin
         failures++;
         $display("FAIL midrfm_no_ack: acks=%0d mem[10]=%0d required 0/0", acks, mem[10]);
      end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int n = 0; n < 40; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r == 0) do_rfm(1'b0, 0);
         else if (r == 9) act_and_check(int'($urandom_range(RN, 127)));
         else act_and_check(int'($urandom_range(0, 9)));
      end
      for (int i = 0; i < RN; i++) if (mem[i] !== 16'(exp_cnt[i])) bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL random_final_contents: got %0d differing entries required 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_counting();
      test_saturation_alert();
      test_rfm_hit();
      test_empty_priority();
      test_reset_mid_rfm();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
